// File: rtl/thermo_cmd_pkg.sv
// Shared types and helpers for the thermostat command return path.
// Command and FSM encodings used by cmd_src_capture and cmd_merge_core.
package thermo_cmd_pkg;

    localparam int DT_W_DEF = 5;

    localparam logic SRC_MAN = 1'b0;
    localparam logic SRC_CEL = 1'b1;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_INCR,
        CMD_DECR,
        CMD_CONF
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN_MAN,
        ST_OWN_CEL
    } state_t;

    // Saturating 8-bit accumulate of 0..3.
    function automatic logic [7:0] satAdd8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/cmd_src_capture.sv
// One command source: rising-edge detection, coincidence resolution and a one-deep pending slot.
// drop_o flags a new command overwriting an occupied slot that is not being issued this cycle.
module cmd_src_capture
    import thermo_cmd_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            incr_i,
    input  logic            decr_i,
    input  logic            conf_i,
    input  logic [DT_W-1:0] dt_i,
    input  logic            issue_i,
    output logic            valid_o,
    output cmd_t            cmd_o,
    output logic [DT_W-1:0] dt_o,
    output logic            drop_o
);

    logic [2:0]      hist_q;
    logic [2:0]      rise;
    cmd_t            newCmd;
    logic            valid_q, valid_d;
    cmd_t            cmd_q, cmd_d;
    logic [DT_W-1:0] dt_q, dt_d;

    // CONF dominates; INCR and DECR rising together cancel each other and leave the slot untouched.
    always_comb begin
        rise    = {conf_i, decr_i, incr_i} & ~hist_q;
        newCmd  = CMD_NONE;
        valid_d = valid_q;
        cmd_d   = cmd_q;
        dt_d    = dt_q;
        if (rise[2]) begin
            newCmd = CMD_CONF;
        end else if (rise[0] && !rise[1]) begin
            newCmd = CMD_INCR;
        end else if (rise[1] && !rise[0]) begin
            newCmd = CMD_DECR;
        end
        if (issue_i) begin
            valid_d = 1'b0;
            cmd_d   = CMD_NONE;
        end
        if (newCmd != CMD_NONE) begin
            valid_d = 1'b1;
            cmd_d   = newCmd;
            if (newCmd == CMD_CONF) begin
                dt_d = dt_i;
            end
        end
        drop_o = (newCmd != CMD_NONE) && valid_q && !issue_i;
    end

    // History resets high so levels held through reset never look like edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q  <= 3'b111;
            valid_q <= 1'b0;
            cmd_q   <= CMD_NONE;
            dt_q    <= '0;
        end else begin
            hist_q  <= {conf_i, decr_i, incr_i};
            valid_q <= valid_d;
            cmd_q   <= cmd_d;
            dt_q    <= dt_d;
        end
    end

    assign valid_o = valid_q;
    assign cmd_o   = cmd_q;
    assign dt_o    = dt_q;

endmodule

// File: rtl/cmd_merge_core.sv
// Merges MAN and CEL command streams into one pulse stream with an ownership lock.
// Optional dropped-command counter enabled by defining DROP_CNT_EN.
module cmd_merge_core
    import thermo_cmd_pkg::*;
#(
    parameter int LOCK_CYC = 20,
    parameter int MAN_PRIO = 1,
    parameter int DT_W     = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            INCR_MAN,
    input  logic            DECR_MAN,
    input  logic            CONF_MAN,
    input  logic [DT_W-1:0] DT_MAN,
    input  logic            INCR_CEL,
    input  logic            DECR_CEL,
    input  logic            CONF_CEL,
    input  logic [DT_W-1:0] DT_CEL,
    output logic            INCR,
    output logic            DECR,
    output logic            CONF,
    output logic [DT_W-1:0] DT,
    output logic            SRC,
    output logic            BUSY,
    output logic [7:0]      DROP_CNT
);

    localparam int TW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC + 1) : 1;

    logic            manValid, celValid, manDrop, celDrop;
    cmd_t            manCmd, celCmd, selCmd;
    logic [DT_W-1:0] manDt, celDt, selDt;
    logic            issueMan, issueCel, expired;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            incr_q, incr_d, decr_q, decr_d, conf_q, conf_d, src_q, src_d;
    logic [DT_W-1:0] dt_q, dt_d;

    cmd_src_capture #(.DT_W(DT_W)) uMan (
        .clk(clk), .rst(rst),
        .incr_i(INCR_MAN), .decr_i(DECR_MAN), .conf_i(CONF_MAN), .dt_i(DT_MAN),
        .issue_i(issueMan),
        .valid_o(manValid), .cmd_o(manCmd), .dt_o(manDt), .drop_o(manDrop)
    );

    cmd_src_capture #(.DT_W(DT_W)) uCel (
        .clk(clk), .rst(rst),
        .incr_i(INCR_CEL), .decr_i(DECR_CEL), .conf_i(CONF_CEL), .dt_i(DT_CEL),
        .issue_i(issueCel),
        .valid_o(celValid), .cmd_o(celCmd), .dt_o(celDt), .drop_o(celDrop)
    );

    // The owner always goes first; the other source only gets in once the lock timer has run out.
    always_comb begin
        issueMan = 1'b0;
        issueCel = 1'b0;
        state_d  = state_q;
        timer_d  = timer_q;
        incr_d   = 1'b0;
        decr_d   = 1'b0;
        conf_d   = 1'b0;
        dt_d     = dt_q;
        src_d    = src_q;
        selCmd   = CMD_NONE;
        selDt    = manDt;
        expired  = (timer_q == '0);

        case (state_q)
            ST_OWN_MAN: begin
                if (manValid) begin
                    issueMan = 1'b1;
                end else if (expired && celValid) begin
                    issueCel = 1'b1;
                end
            end
            ST_OWN_CEL: begin
                if (celValid) begin
                    issueCel = 1'b1;
                end else if (expired && manValid) begin
                    issueMan = 1'b1;
                end
            end
            default: begin
                if (manValid && celValid) begin
                    if (MAN_PRIO != 0) begin
                        issueMan = 1'b1;
                    end else begin
                        issueCel = 1'b1;
                    end
                end else if (manValid) begin
                    issueMan = 1'b1;
                end else if (celValid) begin
                    issueCel = 1'b1;
                end
            end
        endcase

        if (issueMan || issueCel) begin
            selCmd = issueCel ? celCmd : manCmd;
            selDt  = issueCel ? celDt : manDt;
            src_d  = issueCel ? SRC_CEL : SRC_MAN;
            incr_d = (selCmd == CMD_INCR);
            decr_d = (selCmd == CMD_DECR);
            conf_d = (selCmd == CMD_CONF);
            if (selCmd == CMD_CONF) begin
                dt_d = selDt;
            end
            if (LOCK_CYC == 0) begin
                state_d = ST_IDLE;
            end else begin
                state_d = issueCel ? ST_OWN_CEL : ST_OWN_MAN;
                timer_d = TW'(LOCK_CYC);
            end
        end else if (state_q != ST_IDLE) begin
            if (expired) begin
                state_d = ST_IDLE;
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            incr_q  <= 1'b0;
            decr_q  <= 1'b0;
            conf_q  <= 1'b0;
            dt_q    <= '0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            incr_q  <= incr_d;
            decr_q  <= decr_d;
            conf_q  <= conf_d;
            dt_q    <= dt_d;
            src_q   <= src_d;
        end
    end

    assign INCR = incr_q;
    assign DECR = decr_q;
    assign CONF = conf_q;
    assign DT   = dt_q;
    assign SRC  = src_q;
    assign BUSY = (state_q != ST_IDLE);

`ifdef DROP_CNT_EN
    logic [7:0] dropCnt_q, dropCnt_d;

    always_comb begin
        dropCnt_d = satAdd8(dropCnt_q, {1'b0, manDrop} + {1'b0, celDrop});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropCnt_q <= 8'd0;
        end else begin
            dropCnt_q <= dropCnt_d;
        end
    end

    assign DROP_CNT = dropCnt_q;
`else
    logic unusedDrops;
    assign unusedDrops = manDrop ^ celDrop;
    assign DROP_CNT    = 8'd0;
`endif

endmodule
